// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with accumulator, status flags and valid/ready flow control.
// S1 registers the accepted operation; S2 holds the computed result until the consumer takes it.
module alu_pipe #(
  parameter int unsigned WIDTH = 16,
  localparam int unsigned SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alufs,
  input  logic             acc_sel,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu,
  output logic             carry,
  output logic             ovf,
  output logic             zero
);

  // Stage 1 state
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [2:0]       s1_op;
  logic             s1_acc_sel;
  logic             s1_acc_clr;

  // Stage 2 state
  logic             s2_valid;
  logic [WIDTH-1:0] s2_alu;
  logic             s2_carry;
  logic             s2_ovf;
  logic             s2_zero;

  logic [WIDTH-1:0] acc;

  logic             accept;
  logic             advance;
  logic [WIDTH-1:0] opa;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] res_c;
  logic             carry_c;
  logic             ovf_c;

  // S2 frees up whenever it is empty or its result leaves this cycle.
  assign advance  = s1_valid && (!s2_valid || out_ready);
  // Held low during reset so nothing is taken while the pipe is being cleared.
  assign in_ready = reset && (!s1_valid || !s2_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Result and flags for the operation currently sitting in S1.
  always_comb begin
    opa     = s1_acc_sel ? (s1_acc_clr ? '0 : acc) : s1_a;
    sum     = {1'b0, opa} + {1'b0, s1_b};
    diff    = {1'b0, opa} - {1'b0, s1_b};
    res_c   = '0;
    carry_c = 1'b0;
    ovf_c   = 1'b0;
    unique case (s1_op)
      3'b000: res_c = opa;
      3'b001: res_c = opa & s1_b;
      3'b010: begin
        res_c   = sum[WIDTH-1:0];
        carry_c = sum[WIDTH];
        ovf_c   = (opa[WIDTH-1] == s1_b[WIDTH-1]) && (sum[WIDTH-1] != opa[WIDTH-1]);
      end
      3'b011: begin
        res_c   = diff[WIDTH-1:0];
        carry_c = diff[WIDTH];  // borrow: unsigned opa < b
        ovf_c   = (opa[WIDTH-1] != s1_b[WIDTH-1]) && (diff[WIDTH-1] != opa[WIDTH-1]);
      end
      3'b100: res_c = opa | s1_b;
      3'b101: res_c = opa ^ s1_b;
      3'b110: res_c = opa << s1_b[SHW-1:0];
      3'b111: res_c = opa >> s1_b[SHW-1:0];
      default: res_c = '0;
    endcase
  end

  // Stage 1: capture the operation on acceptance, release it when it moves to S2.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid   <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_op      <= '0;
      s1_acc_sel <= 1'b0;
      s1_acc_clr <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid   <= 1'b1;
        s1_a       <= a;
        s1_b       <= b;
        s1_op      <= alufs;
        s1_acc_sel <= acc_sel;
        s1_acc_clr <= acc_clr;
      end else if (advance) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Stage 2 and accumulator: load the computed result on every S1->S2 transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid <= 1'b0;
      s2_alu   <= '0;
      s2_carry <= 1'b0;
      s2_ovf   <= 1'b0;
      s2_zero  <= 1'b0;
      acc      <= '0;
    end else begin
      if (advance) begin
        s2_valid <= 1'b1;
        s2_alu   <= res_c;
        s2_carry <= carry_c;
        s2_ovf   <= ovf_c;
        s2_zero  <= (res_c == '0);
        acc      <= res_c;
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

  // Zero is registered so it reads 0 out of reset rather than reflecting the cleared result.
  assign out_valid = s2_valid;
  assign alu       = s2_alu;
  assign carry     = s2_carry;
  assign ovf       = s2_ovf;
  assign zero      = s2_zero;

endmodule
